// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the serial subtractor.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-chunk build still needs a one-bit counter.
  function automatic int cnt_width(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_chunk.sv
// Combinational CHUNK-bit subtract slice: d_c = a_c - b_c - borrow_i.
// Implemented as a_c + ~b_c + ~borrow_i, with borrow out being the inverted carry.
module sub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_c,
  input  logic [CHUNK-1:0] b_c,
  input  logic             borrow_i,
  output logic [CHUNK-1:0] d_c,
  output logic             borrow_o
);

  logic [CHUNK:0] w_sum;

  assign w_sum    = {1'b0, a_c} + {1'b0, ~b_c} + {{CHUNK{1'b0}}, ~borrow_i};
  assign d_c      = w_sum[CHUNK-1:0];
  assign borrow_o = ~w_sum[CHUNK];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, CHUNK bits per clock, LSB chunk first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = cnt_width(WIDTH, CHUNK);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("serial_subtractor: CHUNK must divide WIDTH");
  end

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_borrow;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_d;
  logic [CHUNK-1:0]   w_a_c;
  logic [CHUNK-1:0]   w_b_c;
  logic [CHUNK-1:0]   w_d_c;
  logic               w_borrow_o;
  logic               w_last;
  logic               w_accept;
  int                 w_lsb;

  assign w_lsb    = int'(r_cnt) * CHUNK;
  assign w_a_c    = r_a[w_lsb +: CHUNK];
  assign w_b_c    = r_b[w_lsb +: CHUNK];
  assign w_last   = (r_cnt == CNT_W'(NCHUNK - 1));
  assign w_accept = (r_state == IDLE) && start_valid;

  sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
    .a_c      (w_a_c),
    .b_c      (w_b_c),
    .borrow_i (r_borrow),
    .d_c      (w_d_c),
    .borrow_o (w_borrow_o)
  );

  // NOTE: operand registers carry no reset; they are always loaded on acceptance before being read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end
  end

  // NOTE: all state updates use <= so every register samples pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_d      <= '0;
    end else begin
      case (r_state)
        IDLE: if (start_valid) begin
          r_cnt    <= '0;
          r_borrow <= b_in;
          r_state  <= CALC;
        end
        CALC: begin
          r_d[w_lsb +: CHUNK] <= w_d_c;
          r_borrow            <= w_borrow_o;
          r_cnt               <= r_cnt + 1'b1;
          if (w_last) r_state <= DONE;
        end
        DONE: if (res_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // Sign of D is only known once the top chunk is produced.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == CALC && w_last) begin
      r_ovf <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_d_c[CHUNK-1] != r_a[WIDTH-1]);
    end
  end

  assign ovf = r_ovf;
`endif

  assign start_ready = (r_state == IDLE);
  assign res_valid   = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign d           = r_d;
  assign b_out       = (r_state == DONE) && r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (default WIDTH=64, CHUNK=8).
// Checks ovf as well when compiled with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         b_in = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] d;
  logic         b_out;
  logic         busy;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W), .CHUNK(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .b_in        (b_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .d           (d),
    .b_out       (b_out),
    .busy        (busy)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands for one edge (the acceptance edge), then scrambles them.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin);
    a = av; b = bv; b_in = bin; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    a = 64'hDEAD_BEEF_0BAD_F00D; b = 64'h1234_5678_9ABC_DEF0; b_in = ~bin;
  endtask

  // Counts edges after acceptance until res_valid, bounded.
  task automatic wait_result(output int cycles);
    cycles = 0;
    while (!res_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic finish_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    n_checks++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready got=%b exp=1", start_ready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (d !== 64'd0) begin n_fail++; $display("FAIL reset_d got=%h exp=0", d); end
    n_checks++; if (b_out !== 1'b0) begin n_fail++; $display("FAIL reset_b_out got=%b exp=0", b_out); end
`ifdef SERIAL_SUB_OVF_EN
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
  endtask

  task automatic test_basic();
    int cyc;
    start_op(64'd10, 64'd3, 1'b0);
    n_checks++; if (busy !== 1'b1 || start_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy got=%b/%b exp=1/0", busy, start_ready); end
    wait_result(cyc);
    n_checks++; if (cyc != 8) begin n_fail++; $display("FAIL basic_latency got=%0d exp=8", cyc); end
    n_checks++; if (d !== 64'd7) begin n_fail++; $display("FAIL basic_d got=%h exp=%h", d, 64'd7); end
    n_checks++; if (b_out !== 1'b0) begin n_fail++; $display("FAIL basic_b_out got=%b exp=0", b_out); end
`ifdef SERIAL_SUB_OVF_EN
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got=%b exp=0", ovf); end
`endif
    finish_result();
    n_checks++; if (res_valid !== 1'b0 || start_ready !== 1'b1) begin n_fail++; $display("FAIL basic_release got=%b/%b exp=0/1", res_valid, start_ready); end
  endtask

  task automatic test_borrow_chain();
    int cyc;
    start_op(64'd0, 64'd1, 1'b0);
    wait_result(cyc);
    n_checks++; if (cyc != 8) begin n_fail++; $display("FAIL chain_latency got=%0d exp=8", cyc); end
    n_checks++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL chain_d got=%h exp=ffffffffffffffff", d); end
    n_checks++; if (b_out !== 1'b1) begin n_fail++; $display("FAIL chain_b_out got=%b exp=1", b_out); end
`ifdef SERIAL_SUB_OVF_EN
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL chain_ovf got=%b exp=0", ovf); end
`endif
    finish_result();
  endtask

  task automatic test_signed_ovf();
    int cyc;
    start_op(64'h8000_0000_0000_0000, 64'd1, 1'b0);
    wait_result(cyc);
    n_checks++; if (d !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL ovf_d got=%h exp=7fffffffffffffff", d); end
    n_checks++; if (b_out !== 1'b0) begin n_fail++; $display("FAIL ovf_b_out got=%b exp=0", b_out); end
`ifdef SERIAL_SUB_OVF_EN
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
`endif
    finish_result();
  endtask

  task automatic test_borrow_in();
    int cyc;
    start_op(64'd5, 64'd5, 1'b1);
    wait_result(cyc);
    n_checks++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL bin1_d got=%h exp=ffffffffffffffff", d); end
    n_checks++; if (b_out !== 1'b1) begin n_fail++; $display("FAIL bin1_b_out got=%b exp=1", b_out); end
    finish_result();
    start_op(64'd5, 64'd5, 1'b0);
    wait_result(cyc);
    n_checks++; if (d !== 64'd0) begin n_fail++; $display("FAIL bin0_d got=%h exp=0", d); end
    n_checks++; if (b_out !== 1'b0) begin n_fail++; $display("FAIL bin0_b_out got=%b exp=0", b_out); end
    finish_result();
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad;
    start_op(64'd100, 64'd58, 1'b1);
    wait_result(cyc);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a = 64'd1; b = 64'd2; start_valid = 1'b1;
      end
      tick();
      start_valid = 1'b0;
      if (d !== 64'd41 || b_out !== 1'b0 || start_ready !== 1'b0 || res_valid !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold got=%0d bad cycles exp=0 (d=%h b_out=%b)", bad, d, b_out); end
    finish_result();
    n_checks++; if (busy !== 1'b0 || start_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ignored got busy=%b start_ready=%b exp=0/1", busy, start_ready); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_op(64'd9, 64'd4, 1'b0);
    wait_result(cyc);
    a = 64'h100; b = 64'h1; b_in = 1'b0;
    res_ready = 1'b1; start_valid = 1'b1;
    tick();
    res_ready = 1'b0;
    n_checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_done_first got busy=%b res_valid=%b exp=0/0", busy, res_valid); end
    tick();
    start_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    wait_result(cyc);
    n_checks++; if (cyc != 8 || d !== 64'hFF) begin n_fail++; $display("FAIL b2b_result got cyc=%0d d=%h exp 8/ff", cyc, d); end
    finish_result();
  endtask

  task automatic test_reset_mid_calc();
    int cyc;
    start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    n_checks++; if (start_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_calc_ctrl got rdy=%b busy=%b vld=%b exp=1/0/0", start_ready, busy, res_valid); end
    n_checks++; if (d !== 64'd0 || b_out !== 1'b0) begin n_fail++; $display("FAIL rst_calc_out got d=%h b_out=%b exp=0/0", d, b_out); end
    rst_n = 1'b1;
    start_op(64'h100, 64'h1, 1'b0);
    wait_result(cyc);
    n_checks++; if (cyc != 8) begin n_fail++; $display("FAIL rst_next_latency got=%0d exp=8", cyc); end
    n_checks++; if (d !== 64'hFF || b_out !== 1'b0) begin n_fail++; $display("FAIL rst_next_result got d=%h b_out=%b exp=ff/0", d, b_out); end
    finish_result();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_borrow_chain();
    test_signed_ovf();
    test_borrow_in();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
